// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit: bus widths, branch op codes,
// PHT counter encodings, redirect FSM states and the packed bus layouts.
// Combinational-only content; no latency or backpressure of its own.
package branch_resolve_unit_pkg;

    localparam int BRESULT_WD       = 68;
    localparam int BPU_TO_DS_BUS_WD = 36;

    localparam logic [3:0] BR_OP_BEQ  = 4'd0;
    localparam logic [3:0] BR_OP_BNE  = 4'd1;
    localparam logic [3:0] BR_OP_BGEZ = 4'd2;
    localparam logic [3:0] BR_OP_BGTZ = 4'd3;
    localparam logic [3:0] BR_OP_BLEZ = 4'd4;
    localparam logic [3:0] BR_OP_BLTZ = 4'd5;
    localparam logic [3:0] BR_OP_J    = 4'd6;
    localparam logic [3:0] BR_OP_JR   = 4'd7;

    localparam logic [1:0] W_TAKEN  = 2'b00;
    localparam logic [1:0] S_TAKEN  = 2'b01;
    localparam logic [1:0] WN_TAKEN = 2'b10;
    localparam logic [1:0] SN_TAKEN = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_DS  = 2'd1,
        ST_REDIRECT = 2'd2
    } bru_state_e;

    typedef struct packed {
        logic        pred_taken;
        logic [1:0]  pred_count;
        logic        pred_valid;
        logic [31:0] pred_target;
    } bpu_bus_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [1:0]  old_count;
        logic        is_branch;
        logic        br_taken;
        logic [31:0] br_target;
    } bresult_t;

endpackage

// File: rtl/bru_target_calc.sv
// Branch condition and target evaluation for one EXE-stage branch/jump.
// Purely combinational, zero latency; no handshake, always produces a result.
module bru_target_calc
    import branch_resolve_unit_pkg::*;
#(
    parameter int PC_WD = 32
) (
    input  logic [3:0]       br_op,
    input  logic [PC_WD-1:0] pc,
    input  logic [PC_WD-1:0] rs_val,
    input  logic [PC_WD-1:0] rt_val,
    input  logic [15:0]      imm16,
    input  logic [25:0]      instr_index,
    output logic             taken,
    output logic [PC_WD-1:0] target,
    output logic [PC_WD-1:0] seq_pc
);

    logic [PC_WD-1:0] pc4;
    logic [PC_WD-1:0] br_tgt;
    logic             rs_neg;
    logic             rs_zero;
    logic             ops_eq;

    assign pc4     = pc + PC_WD'(4);
    assign seq_pc  = pc + PC_WD'(8);
    assign br_tgt  = pc4 + PC_WD'({{14{imm16[15]}}, imm16, 2'b00});
    assign rs_neg  = rs_val[PC_WD-1];
    assign rs_zero = (rs_val == '0);
    assign ops_eq  = (rs_val == rt_val);

    always_comb begin
        taken  = 1'b0;
        target = br_tgt;
        case (br_op)
            BR_OP_BEQ:  taken = ops_eq;
            BR_OP_BNE:  taken = !ops_eq;
            BR_OP_BGEZ: taken = !rs_neg;
            BR_OP_BGTZ: taken = !rs_neg && !rs_zero;
            BR_OP_BLEZ: taken = rs_neg || rs_zero;
            BR_OP_BLTZ: taken = rs_neg;
            BR_OP_J: begin
                taken  = 1'b1;
                target = {pc4[PC_WD-1:PC_WD-4], instr_index, 2'b00};
            end
            BR_OP_JR: begin
                taken  = 1'b1;
                target = rs_val;
            end
            // Undefined ops behave as a never-taken non-branch.
            default:    target = '0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// EXE-stage branch resolution: checks prediction, redirects fetch after the delay slot, trains PHT via BResult.
// BResult one cycle after fire; redirect issued once the delay slot is in ID, held until fetch accepts.
// Backpressure: br_allowin low while a redirect is pending. Optional BRU_PERF_CNT_EN adds fire/mispredict counters.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int         PC_WD       = 32,
    parameter logic [1:0] NT_INIT_CNT = WN_TAKEN
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        es_br_valid,
    input  logic [PC_WD-1:0]            es_pc,
    input  logic [3:0]                  es_br_op,
    input  logic [PC_WD-1:0]            es_rs_val,
    input  logic [PC_WD-1:0]            es_rt_val,
    input  logic [15:0]                 es_imm16,
    input  logic [25:0]                 es_instr_index,
    input  logic [BPU_TO_DS_BUS_WD-1:0] es_bpu_bus,
    input  logic                        ds_valid,
    input  logic                        ws_flush,
    input  logic                        fs_redirect_ready,
    output logic                        br_allowin,
    output logic                        redirect_valid,
    output logic [PC_WD-1:0]            redirect_target,
    output logic                        flush_fs,
    output logic [BRESULT_WD-1:0]       BResult
`ifdef BRU_PERF_CNT_EN
    ,
    output logic [31:0]                 perf_br_cnt,
    output logic [31:0]                 perf_mis_cnt
`endif
);

    bpu_bus_t         bpu;
    bresult_t         bres_d;
    bru_state_e       state_q, state_d;
    logic             taken;
    logic [PC_WD-1:0] target;
    logic [PC_WD-1:0] seq_pc;
    logic             fire;
    logic             mispredict;
    logic             latch_en;
    logic [PC_WD-1:0] redirect_pc;

    assign bpu = es_bpu_bus;

    bru_target_calc #(.PC_WD(PC_WD)) u_target_calc (
        .br_op       (es_br_op),
        .pc          (es_pc),
        .rs_val      (es_rs_val),
        .rt_val      (es_rt_val),
        .imm16       (es_imm16),
        .instr_index (es_instr_index),
        .taken       (taken),
        .target      (target),
        .seq_pc      (seq_pc)
    );

    assign br_allowin = (state_q == ST_IDLE);
    assign fire       = es_br_valid && br_allowin;
    assign mispredict = bpu.pred_valid ? ((bpu.pred_taken != taken) ||
                                          (taken && (bpu.pred_target != target)))
                                       : taken;

    always_comb begin
        state_d        = state_q;
        latch_en       = 1'b0;
        redirect_valid = 1'b0;
        flush_fs       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fire && mispredict && !ws_flush) begin
                    latch_en = 1'b1;
                    state_d  = ds_valid ? ST_REDIRECT : ST_WAIT_DS;
                end
            end
            ST_WAIT_DS: begin
                if (ds_valid) state_d = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                redirect_valid = !ws_flush;
                flush_fs       = !ws_flush;
                if (fs_redirect_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // A pipeline flush outranks any pending redirect.
        if (ws_flush) state_d = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            redirect_pc <= '0;
        end else begin
            state_q <= state_d;
            if (latch_en) redirect_pc <= taken ? target : seq_pc;
        end
    end

    assign redirect_target = redirect_pc;

    always_comb begin
        bres_d.pc        = es_pc;
        bres_d.old_count = bpu.pred_valid ? bpu.pred_count : NT_INIT_CNT;
        bres_d.is_branch = (es_br_op <= BR_OP_BLTZ);
        bres_d.br_taken  = taken;
        bres_d.br_target = target;
    end

    // Training record is independent of ws_flush: every fire is reported once.
    always_ff @(posedge clk) begin
        if (reset)     BResult <= '0;
        else if (fire) BResult <= bres_d;
        else           BResult <= '0;
    end

`ifdef BRU_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_br_cnt  <= '0;
            perf_mis_cnt <= '0;
        end else if (fire && !ws_flush) begin
            perf_br_cnt <= perf_br_cnt + 32'd1;
            if (mispredict) perf_mis_cnt <= perf_mis_cnt + 32'd1;
        end
    end
`endif

endmodule
